ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares the single-port data RAM between the CPU load/store path (port 0) and a loader/debug master (port 1). It sits between the CPU datapath's data-memory connection and the `ram` instance. It does round-robin arbitration with an optional bus lock for multi-word transfers and a lock-timeout guard against starvation. It returns read data one cycle after acceptance, tagged to the port that issued the read.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_LOCK`, 16, maximum consecutive locked grants before forced release (≥1)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req0`/`req1`  in  1  access request, port 0 (CPU) / port 1 (loader)
- `we0`/`we1`  in  1  1 = write, 0 = read
- `lock0`/`lock1`  in  1  hold ownership after this access
- `addr0`/`addr1`  in  AW  byte address
- `wdata0`/`wdata1`  in  DW  write data
- `gnt0`/`gnt1`  out  1  access accepted this cycle (combinational)
- `rvalid0`/`rvalid1`  out  1  read data valid for the port
- `rdata0`/`rdata1`  out  DW  read data
- `mem_we`  out  1  RAM write enable
- `mem_addr`  out  AW  RAM address
- `mem_wdata`  out  DW  RAM write data
- `mem_rdata`  in  DW  RAM read data, valid 1 cycle after the address

## Operation
- An access is accepted when `reqN && gntN`. At most one grant is issued per cycle. `mem_*` carry the granted port's `we`/`addr`/`wdata`. With no grant, `mem_we`=0 and `mem_addr`/`mem_wdata`=0.
- Owner FSM states are `OWN_NONE`, `OWN_P0` and `OWN_P1`. The reset state is `OWN_NONE`.
  - `OWN_NONE`, one request: grant it.
  - `OWN_NONE`, both request: grant the port ≠ `rr_last`. `rr_last` resets to 1, so the CPU wins the first tie.
  - Accepted access with `lockN`=1: go to `OWN_PN`.
  - `OWN_PN`: only port N can be granted, even if `reqN`=0 (the other port waits).
  - Leave to `OWN_NONE` when port N has an accepted access with `lockN`=0, or when a cycle has `reqN`=0 and `lockN`=0.
- `rr_last` updates to the granted port index on every accepted access.
- Lock timer: counts accepted accesses while in `OWN_PN`.
  - When the count reaches `MAX_LOCK` and the other port is requesting, the FSM returns to `OWN_NONE`. In the next cycle the other port has absolute priority, regardless of `rr_last`.
  - The counter clears on entry to `OWN_NONE`.
- Read return: an accepted read sets `rvalidN` in the next cycle. `rdataN` = `mem_rdata` while `rvalidN`=1, and 0 otherwise.
- Writes produce no `rvalid`.

## Timing
- Grant is same-cycle and combinational from `req*`, `lock*`, the FSM state and `rr_last`. There are no comb loops through `mem_rdata`.
- Read latency is 1 cycle from acceptance to `rvalid`. Back-to-back accesses (including alternating ports) are sustained at 1 per cycle.
- Reset values: `gnt*`=0, `rvalid*`=0, `rdata*`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, FSM=`OWN_NONE`, `rr_last`=1, lock count=0. Grants are forced 0 while `reset`=0.
- Reset asserted mid-operation drops any pending `rvalid`. Nothing is replayed.
- If `lockN` is asserted together with a denied request, it has no effect.
- `MAX_LOCK`=1 degenerates to alternating ownership under contention.

## Structure
- The package `arb_pkg` holds:
  - the typedef `owner_e` (`OWN_NONE`, `OWN_P0`, `OWN_P1`);
  - the constants `PORT_CPU`=0 and `PORT_LDR`=1.
- The sub-module `lock_timer` holds a saturating count to `MAX_LOCK`, with inputs `inc`/`clr` and output `expired`.
- The FSM, grant logic and read-tag register live in `ram_arbiter`.

## Test plan
- CPU-only reads: `req0` read at addr 0x10, RAM holds 0xDEADBEEF → `gnt0`=1 the same cycle, next cycle `rvalid0`=1 and `rdata0`=0xDEADBEEF, `rvalid1`=0.
- Tie after reset: both ports request every cycle for 4 cycles, no lock → grants go P0, P1, P0, P1. `rvalid` is tagged to the correct port each cycle.
- Lock burst: P1 writes 0x0..0xC with `lock1`=1 and clears `lock1` on the 4th write, while P0 requests throughout → `gnt0`=0 for 4 cycles, then `gnt0`=1 in cycle 5.
- Lock timeout (`MAX_LOCK`=16): P1 holds lock indefinitely while P0 requests → 16 P1 grants, then 1 P0 grant, then P1 may re-acquire.
- Lock release on idle: P0 is granted with `lock0`=1, then `req0`=0 and `lock0`=0 for one cycle → FSM returns to `OWN_NONE` and a pending P1 request is granted the following cycle.
- Reset mid-read: accepted read, then `reset` driven 0 before the next edge → `rvalid0` stays 0, all outputs at reset values, and the first tie after release goes to P0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the data-RAM arbiter: bus-owner encoding and port indices.
package arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  function automatic owner_e owner_of(input logic port);
    return port ? OWN_P1 : OWN_P0;
  endfunction

endpackage

// File: rtl/ram_arbiter_lock_timer.sv
// Saturating count of locked grants; flags when the owner has used up its lock budget.
module lock_timer #(
  parameter int MAX_LOCK = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_LOCK);

  logic [CW-1:0] count_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != LIMIT)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Looks ahead by one increment so the release happens on the grant that hits the limit.
  assign expired = (count_q == LIMIT) || (inc && (count_q == LIMIT - 1'b1));

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU (port 0) and
// the loader (port 1), with bus lock, lock timeout and port-tagged read return.
module ram_arbiter
  import arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0] req;
  logic [1:0] lock;
  logic [1:0] we;
  logic [1:0] gnt;

  assign req  = {req1, req0};
  assign lock = {lock1, lock0};
  assign we   = {we1, we0};

  owner_e     state_q;
  owner_e     state_d;
  logic       rr_last_q;
  logic       prio_q;
  logic       prio_port_q;
  logic       set_prio;
  logic       prio_port_d;
  logic [1:0] rvalid_q;

  logic any_gnt;
  logic gnt_port;
  logic owner_port;
  logic timer_inc;
  logic timer_clr;
  logic timer_expired;

  assign any_gnt  = |gnt;
  assign gnt_port = gnt[1];

  // In OWN_NONE the port that might take the lock is the one granted now.
  assign owner_port  = (state_q == OWN_NONE) ? gnt_port : (state_q == OWN_P1);
  assign prio_port_d = ~owner_port;

  assign timer_inc = any_gnt && ((state_q != OWN_NONE) || lock[gnt_port]);
  assign timer_clr = (state_d == OWN_NONE);

  lock_timer #(
    .MAX_LOCK(MAX_LOCK)
  ) u_lock_timer (
    .clk    (clk),
    .rst_n  (reset),
    .inc    (timer_inc),
    .clr    (timer_clr),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= OWN_NONE;
      rr_last_q   <= PORT_LDR;
      prio_q      <= 1'b0;
      prio_port_q <= PORT_CPU;
      rvalid_q    <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= set_prio;
      rvalid_q <= gnt & ~we;
      if (any_gnt) begin
        rr_last_q <= gnt_port;
      end
      if (set_prio) begin
        prio_port_q <= prio_port_d;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    set_prio = 1'b0;
    case (state_q)
      OWN_NONE: begin
        if (any_gnt && lock[gnt_port]) begin
          if (timer_expired && req[~gnt_port]) begin
            set_prio = 1'b1;
          end else begin
            state_d = owner_of(gnt_port);
          end
        end
      end
      OWN_P0, OWN_P1: begin
        if (timer_expired && req[~owner_port]) begin
          state_d  = OWN_NONE;
          set_prio = 1'b1;
        end else if (!lock[owner_port]) begin
          // Covers both an unlocked final access and an idle cycle without lock.
          state_d = OWN_NONE;
        end
      end
      default: state_d = OWN_NONE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (reset) begin
      case (state_q)
        OWN_NONE: begin
          if (prio_q && req[prio_port_q]) begin
            gnt[prio_port_q] = 1'b1;
          end else if (req == 2'b11) begin
            gnt[~rr_last_q] = 1'b1;
          end else begin
            gnt = req;
          end
        end
        OWN_P0:  gnt[0] = req[0];
        OWN_P1:  gnt[1] = req[1];
        default: gnt = '0;
      endcase
    end

    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[0]) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt[1]) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end

    rdata0 = rvalid_q[0] ? mem_rdata : '0;
    rdata1 = rvalid_q[1] ? mem_rdata : '0;
  end

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: grants checked per cycle, read returns via a scoreboard queue.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct {
    int          cyc;
    bit          port;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  string       phase = "init";
  logic [31:0] ram    [0:63];
  logic [31:0] shadow [0:63];

  ram_arbiter #(
    .AW(32), .DW(32), .MAX_LOCK(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h (cycle %0d)", phase, name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit r0, input bit w0, input bit l0, input logic [31:0] a0,
                       input logic [31:0] d0, input bit r1, input bit w1, input bit l1,
                       input logic [31:0] a1, input logic [31:0] d1);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  // Checks the grant and RAM bus for the current cycle, books the expected read return,
  // then advances to just after the next rising edge.
  task automatic step(input bit eg0, input bit eg1, input bit ret_ok = 1'b1);
    exp_t        it;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    check("gnt0", gnt0, eg0);
    check("gnt1", gnt1, eg1);
    e_we    = eg0 ? we0    : (eg1 ? we1    : 1'b0);
    e_addr  = eg0 ? addr0  : (eg1 ? addr1  : 32'h0);
    e_wdata = eg0 ? wdata0 : (eg1 ? wdata1 : 32'h0);
    check("mem_we", mem_we, e_we);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    if ((eg0 || eg1) && !e_we && ret_ok) begin
      it.cyc  = cyc + 1;
      it.port = eg1;
      it.data = shadow[e_addr[7:2]];
      sb.push_back(it);
    end
    if ((eg0 || eg1) && e_we) shadow[e_addr[7:2]] = e_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("gnt0_rst", gnt0, 1'b0);
    check("gnt1_rst", gnt1, 1'b0);
    check("mem_we_rst", mem_we, 1'b0);
    check("mem_addr_rst", mem_addr, 32'h0);
    check("mem_wdata_rst", mem_wdata, 32'h0);
    check("rdata0_rst", rdata0, 32'h0);
    check("rdata1_rst", rdata1, 32'h0);
  endtask

  // Read-return monitor: pops the scoreboard whenever a return is due and
  // requires silence on both rvalid lines otherwise.
  exp_t        mon_item;
  logic        mon_v0, mon_v1;
  logic [31:0] mon_d;
  always @(negedge clk) begin
    mon_v0 = 1'b0;
    mon_v1 = 1'b0;
    mon_d  = 32'h0;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      check("rvalid_cycle", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_item = sb.pop_front();
      if (mon_item.port) mon_v1 = 1'b1;
      else               mon_v0 = 1'b1;
      mon_d = mon_item.data;
    end
    check("rvalid0", rvalid0, mon_v0);
    check("rvalid1", rvalid1, mon_v1);
    check("rdata0", rdata0, mon_v0 ? mon_d : 32'h0);
    check("rdata1", rdata1, mon_v1 ? mon_d : 32'h0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach the summary (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i]    = 32'h1000_0000 + i;
      shadow[i] = 32'h1000_0000 + i;
    end
    ram[4]    = 32'hDEAD_BEEF;
    shadow[4] = 32'hDEAD_BEEF;

    // Reset with both ports requesting: grants must stay low.
    phase = "reset";
    reset = 1'b0;
    drive(1, 0, 0, 32'h20, 32'h0, 1, 0, 0, 32'h24, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs();
    end
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // First ties after reset alternate starting with the CPU.
    phase = "tie";
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 32'h20 + 8 * i, 32'h0, 1, 0, 0, 32'h24 + 8 * i, 32'h0);
      step(i % 2 == 0, i % 2 == 1);
    end

    phase = "cpu_read";
    drive(1, 0, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0);

    // rr_last now favours the loader, which takes the bus for a 4-word locked burst.
    phase = "lock_burst";
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 32'h40, 32'h0, 1, 1, k < 3, 4 * k, 32'hC0DE_0000 + k);
      step(0, 1);
    end
    drive(1, 0, 0, 32'h40, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0);
    drive(1, 0, 0, 32'h8, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0);
    drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'hC, 32'h0);
    step(0, 1);

    // Loader keeps the lock forever; the CPU must get in after 16 loader grants.
    phase = "lock_timeout";
    drive(0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h80, 32'h0D00_0000);
    step(0, 1);
    for (int k = 1; k < 16; k++) begin
      drive(1, 0, 0, 32'h10, 32'h0, 1, 1, 1, 32'h80 + 4 * k, 32'h0D00_0000 + k);
      step(0, 1);
    end
    drive(1, 0, 0, 32'h10, 32'h0, 1, 1, 1, 32'hC0, 32'h0D00_00C0);
    step(1, 0);
    drive(1, 0, 0, 32'h10, 32'h0, 1, 1, 1, 32'hC0, 32'h0D00_00C0);
    step(0, 1);
    idle();
    step(0, 0);

    // CPU takes the lock, holds through an idle locked cycle, then releases by going idle.
    phase = "idle_release";
    drive(1, 0, 1, 32'h84, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0);
    drive(0, 0, 1, 32'h0, 32'h0, 1, 0, 0, 32'h10, 32'h0);
    step(0, 0);
    drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h10, 32'h0);
    step(0, 0);
    drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h10, 32'h0);
    step(0, 1);

    // Read accepted, then reset lands before its data would be returned.
    phase = "reset_mid_read";
    drive(1, 0, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 1'b0);
    reset = 1'b0;
    drive(1, 0, 0, 32'h20, 32'h0, 1, 0, 0, 32'h24, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs();
    end
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, 0, 32'h20, 32'h0, 1, 0, 0, 32'h24, 32'h0);
    step(1, 0);
    idle();
    step(0, 0);
    step(0, 0);

    phase = "end";
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
